// File: rtl/zxuno_regs_port_if.sv
// Z80 I/O bus as seen by the ZX-UNO register port: the CPU drives
// address, strobes and write data; the register port only listens.
interface zxuno_regs_port_if;
   logic [15:0] a;
   logic        iorq_n;
   logic        rd_n;
   logic        wr_n;
   logic [7:0]  din;

   modport master (output a, iorq_n, rd_n, wr_n, din);
   modport slave  (input  a, iorq_n, rd_n, wr_n, din);
endinterface

// File: rtl/zxuno_regs_port.sv
// ZX-UNO register-select / register-data port: latches the selected register
// number and turns long Z80 I/O cycles into single-cycle qualifiers.
module zxuno_regs_port #(
   parameter logic [15:0] ADDR_PORT  = 16'hFC3B,
   parameter logic [15:0] DATA_PORT  = 16'hFD3B,
   parameter logic [7:0]  RESET_ADDR = 8'h00
) (
   input  logic                     clk,
   input  logic                     rst_n,
   zxuno_regs_port_if.slave         bus,
   output wire  [7:0]               dout,
   output logic                     oe_n,
   output logic [7:0]               zxuno_addr,
   output logic                     zxuno_regrd,
   output logic                     zxuno_regwr,
   output logic                     regaddr_changed
);

   logic wr_addr, wr_data, rd_addr, rd_data;
   logic wa_first, wd_first;
   logic [7:0] addr_d;

   logic       prev_wa_q, prev_wd_q;
   logic [7:0] addr_q;
   logic       changed_q, regwr_q, regrd_q;

   // Full 16-bit decode; no aliasing of the two ports.
   always_comb begin
      wr_addr  = !bus.iorq_n && !bus.wr_n && (bus.a == ADDR_PORT);
      wr_data  = !bus.iorq_n && !bus.wr_n && (bus.a == DATA_PORT);
      rd_addr  = !bus.iorq_n && !bus.rd_n && (bus.a == ADDR_PORT);
      rd_data  = !bus.iorq_n && !bus.rd_n && (bus.a == DATA_PORT);
      wa_first = wr_addr && !prev_wa_q;
      wd_first = wr_data && !prev_wd_q;
      addr_d   = wa_first ? bus.din : addr_q;
   end

   // The "previous" flags reset to 1 so an access already in flight at reset
   // release is treated as old and never produces a strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_wa_q <= 1'b1;
         prev_wd_q <= 1'b1;
         addr_q    <= RESET_ADDR;
         changed_q <= 1'b0;
         regwr_q   <= 1'b0;
         regrd_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop reading the
         // pre-edge value of its neighbours, independent of statement order.
         prev_wa_q <= wr_addr;
         prev_wd_q <= wr_data;
         addr_q    <= addr_d;
         changed_q <= wa_first;
         regwr_q   <= wd_first;
         regrd_q   <= rd_data;
      end
   end

   // Read-back of the selected register number on the address port.
   assign oe_n = !rd_addr;
   assign dout = oe_n ? 8'hzz : addr_q;

   assign zxuno_addr      = addr_q;
   assign zxuno_regrd     = regrd_q;
   assign zxuno_regwr     = regwr_q;
   assign regaddr_changed = changed_q;

endmodule

// File: doc/zxuno_regs_port.md
Name: zxuno_regs_port

Overview:
- Upstream stage of every ZX-UNO extended-register block, including the core-ID text register at 0xFF.
- Decodes Z80 I/O cycles on the register-address port and the register-data port.
- Holds the currently selected register number.
- Generates the address/read/write/address-changed qualifiers that downstream register blocks consume.
- Also answers CPU reads of the address port with the latched register number.

Parameters:
ADDR_PORT, 16'hFC3B, I/O address of register-select port
DATA_PORT, 16'hFD3B, I/O address of register-data port
RESET_ADDR, 8'h00, value of selected register after reset

Ports:
clk  input  1  system clock; all bus inputs synchronous to it
rst_n  input  1  asynchronous active-low reset
a  input  16  Z80 address bus
iorq_n  input  1  Z80 IORQ, active low
rd_n  input  1  Z80 RD, active low
wr_n  input  1  Z80 WR, active low
din  input  8  Z80 data bus (CPU to device)
dout  output  8  read-back data; 8'hZZ when oe_n=1
oe_n  output  1  low while this block drives dout
zxuno_addr  output  8  currently selected register number
zxuno_regrd  output  1  level: CPU read of DATA_PORT in progress
zxuno_regwr  output  1  one-cycle pulse: CPU write to DATA_PORT
regaddr_changed  output  1  one-cycle pulse: CPU wrote ADDR_PORT

Behaviour:
- Reset: asynchronous, active-low (rst_n), single clock clk.
  - zxuno_addr=RESET_ADDR; zxuno_regwr=0; regaddr_changed=0.
  - Access-tracking flags reset to 1 ("access in progress"). If iorq_n is already low at reset release, no strobe fires until that access ends.
- Decode (combinational):
  - wr_addr = !iorq_n & !wr_n & a==ADDR_PORT.
  - wr_data = !iorq_n & !wr_n & a==DATA_PORT.
  - rd_addr = !iorq_n & !rd_n & a==ADDR_PORT.
  - rd_data = !iorq_n & !rd_n & a==DATA_PORT.
  - Full 16-bit compare; no partial decoding.
- Address write:
  - Each clk edge registers wr_addr into prev_wa.
  - On the first edge where wr_addr=1 and prev_wa=0: zxuno_addr<=din and regaddr_changed<=1 for exactly one cycle.
  - Later cycles of the same access do not change zxuno_addr, even if din changes.
  - Writing the same value again still pulses regaddr_changed; downstream blocks use this to rewind.
- Data write:
  - Same edge tracking (prev_wd). zxuno_regwr<=1 for exactly one cycle, on the edge after the first sampled cycle of wr_data.
  - din is not latched here; consumers sample din while zxuno_regwr=1. The Z80 write cycle spans many clk cycles, so din is still valid then.
- Data read:
  - zxuno_regrd = registered rd_data, 1-cycle latency.
  - Stays high for the whole access and drops 1 cycle after rd_data falls.
  - Downstream blocks count its falling edges; glitch-free is required, so no combinational path.
- Address read:
  - oe_n = !rd_addr (combinational).
  - dout = zxuno_addr when oe_n=0, else 8'hZZ.
  - Reads of DATA_PORT are not answered here; oe_n stays 1.
- Back-to-back accesses: a new strobe requires the decode term to be sampled 0 for at least one edge between accesses.
- Simultaneous: the address write and the data write are mutually exclusive by decode. If iorq_n rises in the same cycle a strobe is registered, the strobe still completes its single cycle.
- Reset asserted mid-access:
  - Outputs clear immediately.
  - Flags return to 1, so the interrupted access never produces a strobe after release.

Test Plan:
- Reset, then idle bus → zxuno_addr=8'h00, oe_n=1, dout=Z, all strobes 0.
- Write 8'hFF to FC3B; iorq_n/wr_n low for 6 cycles → zxuno_addr=8'hFF one cycle after the first sampled cycle; regaddr_changed high exactly 1 cycle; repeat the write with 8'hFF → second single pulse.
- Read FD3B for 5 cycles, idle 3, read again → zxuno_regrd high 5 cycles delayed by 1, low 3, high again; oe_n stays 1.
- Read FC3B after writing 8'h0A → oe_n=0 and dout=8'h0A while rd_n low; dout=Z after.
- Write 8'h55 to FD3B, din changes to 8'hAA on cycle 3 → zxuno_regwr one pulse, while din=8'h55; zxuno_addr unchanged.
- Hold a write to FC3B active, pulse rst_n low for 2 cycles, release with iorq_n still low → zxuno_addr=8'h00, no regaddr_changed until iorq_n goes high and a new write occurs.
